lcd_receiver: RTL and testbench

Synthesizable receiver for the 8-bit HD44780-style parallel bus that `lcd_unit` drives (`lcd_data`, `lcd_ctrl`, `lcd_enable`). It decodes the subset of the instruction set our firmware uses and keeps a 2×16 character DDRAM image. A read port exposes that image so the video path can mirror the LCD on VGA, and simulation can check LCD output. It runs in the CPU clock domain, next to `lcd_unit`.

---
 rtl/lcd_pkg.sv | 30 +++
 rtl/lcd_receiver_if.sv | 9 +
 rtl/lcd_ddram.sv | 29 ++
 rtl/lcd_receiver.sv | 139 +++++++++++++
 tb/tb_lcd_receiver.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus: command bits, ctrl bit indices,
// the clear character and the receiver state encoding.
package lcd_pkg;

  localparam int CMD_CLEAR     = 0;
  localparam int CMD_HOME      = 1;
  localparam int CMD_ENTRY     = 2;
  localparam int CMD_DISPLAY   = 3;
  localparam int CMD_SET_DDRAM = 7;

  localparam int CTRL_RS = 0;
  localparam int CTRL_RW = 1;

  localparam logic [7:0] CLEAR_CHAR  = 8'h20;
  localparam int         ADDR_W      = 5;
  localparam int         DDRAM_DEPTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_WAIT  = 2'd2
  } lcd_state_t;

  // Cursor moves one step in the entry direction, wrapping over the 32-entry image.
  function automatic logic [ADDR_W-1:0] cursor_step(input logic [ADDR_W-1:0] cur,
                                                    input logic              inc);
    return inc ? cur + ADDR_W'(1) : cur - ADDR_W'(1);
  endfunction

endpackage

// File: rtl/lcd_receiver_if.sv
// Parallel LCD bus as driven by lcd_unit: 8-bit data, RS/RW control and the E strobe.
interface lcd_receiver_if;
  logic [7:0] lcd_data;
  logic [1:0] lcd_ctrl;
  logic       lcd_enable;

  modport master (output lcd_data, output lcd_ctrl, output lcd_enable);
  modport slave  (input  lcd_data, input  lcd_ctrl, input  lcd_enable);
endinterface

// File: rtl/lcd_ddram.sv
// 32x8 character image: one synchronous write port, one registered read port
// (read-before-write on a same-index collision).
module lcd_ddram
  import lcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [7:0]        o_rdata
);

  logic [7:0] r_mem [DDRAM_DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rdata <= 8'h00;
    else     r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/lcd_receiver.sv
// Receiver for the HD44780-style bus: decodes the firmware's command subset and
// maintains a 2x16 DDRAM image readable by the video path.
module lcd_receiver
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES = 40
) (
  input  logic              clk,
  input  logic              rst,
  lcd_receiver_if.slave     bus,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] cursor,
  output logic              display_on,
  output logic              increment,
  output logic              busy,
  output logic              overrun
);

  localparam int                CNT_W    = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(BUSY_CYCLES - 1);

  logic              r_en_q;
  logic [7:0]        r_data_q;
  logic [1:0]        r_ctrl_q;
  lcd_state_t        r_state;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_cursor;
  logic              r_display_on;
  logic              r_increment;
  logic              r_busy;
  logic              r_overrun;

  logic              w_fall;
  logic              w_evt;
  logic              w_accept;
  logic              w_rs;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [7:0]        w_wdata;

  always_ff @(posedge clk) begin
    r_data_q <= bus.lcd_data;
    r_ctrl_q <= bus.lcd_ctrl;
  end

  // A transaction is the falling edge of E; reads (RW=1) are invisible to the receiver.
  assign w_fall   = r_en_q & ~bus.lcd_enable;
  assign w_evt    = w_fall & ~r_ctrl_q[CTRL_RW];
  assign w_accept = w_evt & (r_state == ST_IDLE);
  assign w_rs     = r_ctrl_q[CTRL_RS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en_q       <= 1'b0;
      r_state      <= ST_CLEAR;
      r_clr_idx    <= '0;
      r_cnt        <= '0;
      r_cursor     <= '0;
      r_display_on <= 1'b0;
      r_increment  <= 1'b1;
      r_busy       <= 1'b1;
      r_overrun    <= 1'b0;
    end else begin
      r_en_q <= bus.lcd_enable;
      if (w_evt && (r_state != ST_IDLE)) r_overrun <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_busy  <= 1'b1;
            r_state <= ST_WAIT;
            r_cnt   <= CNT_LOAD;
            if (w_rs) begin
              r_cursor <= cursor_step(r_cursor, r_increment);
            end else if (r_data_q[CMD_SET_DDRAM]) begin
              r_cursor <= {r_data_q[6], r_data_q[3:0]};
            end else if (r_data_q[6:4] == 3'b000) begin
              if (r_data_q[CMD_DISPLAY]) begin
                r_display_on <= r_data_q[2];
              end else if (r_data_q[CMD_ENTRY]) begin
                r_increment <= r_data_q[1];
              end else if (r_data_q[CMD_HOME]) begin
                r_cursor <= '0;
              end else if (r_data_q[CMD_CLEAR]) begin
                r_cursor    <= '0;
                r_increment <= 1'b1;
                r_clr_idx   <= '0;
                r_state     <= ST_CLEAR;
              end
            end
          end
        end
        ST_CLEAR: begin
          r_clr_idx <= r_clr_idx + ADDR_W'(1);
          if (r_clr_idx == ADDR_W'(DDRAM_DEPTH - 1)) begin
            r_state <= ST_WAIT;
            r_cnt   <= CNT_LOAD;
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Clear sweep and data writes never coincide: data writes are only accepted in IDLE.
  assign w_we    = (r_state == ST_CLEAR) | (w_accept & w_rs);
  assign w_waddr = (r_state == ST_CLEAR) ? r_clr_idx : r_cursor;
  assign w_wdata = (r_state == ST_CLEAR) ? CLEAR_CHAR : r_data_q;

  lcd_ddram u_ddram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (rd_addr),
    .o_rdata (rd_data)
  );

  assign cursor     = r_cursor;
  assign display_on = r_display_on;
  assign increment  = r_increment;
  assign busy       = r_busy;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_lcd_receiver.sv
// Directed bench for lcd_receiver: bus transactions, DDRAM reads through a scoreboard,
// busy timing, overrun, clear and reset-during-clear.
module tb_lcd_receiver;
  import lcd_pkg::*;

  localparam int BUSY_CYCLES = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [4:0] cursor;
  logic       display_on;
  logic       increment;
  logic       busy;
  logic       overrun;

  lcd_receiver_if bus ();

  lcd_receiver #(.BUSY_CYCLES(BUSY_CYCLES)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cursor     (cursor),
    .display_on (display_on),
    .increment  (increment),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] sb_q [$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic rs, input logic rw, input logic [7:0] d);
    bus.lcd_ctrl   = {rw, rs};
    bus.lcd_data   = d;
    bus.lcd_enable = 1'b1;
    tick(1);
    bus.lcd_enable = 1'b0;
    tick(1);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    busy_len(n);
    chk(tag, 32'(n < 200), 32'd1);
  endtask

  task automatic rd_chk(input logic [4:0] a, input logic [7:0] exp);
    logic [7:0] e;
    rd_addr = a;
    sb_q.push_back(exp);
    tick(1);
    e = sb_q.pop_front();
    chk($sformatf("rd[%0d]", a), 32'(rd_data), 32'(e));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst            = 1'b1;
    bus.lcd_data   = 8'h00;
    bus.lcd_ctrl   = 2'b00;
    bus.lcd_enable = 1'b0;
    rd_addr        = 5'd3;
    tick(3);

    // Reset values, plus an E strobe that starts and ends inside reset.
    chk("rst rd_data", 32'(rd_data), 32'h00);
    chk("rst cursor", 32'(cursor), 32'd0);
    chk("rst display_on", 32'(display_on), 32'd0);
    chk("rst increment", 32'(increment), 32'd1);
    chk("rst busy", 32'(busy), 32'd1);
    chk("rst overrun", 32'(overrun), 32'd0);
    bus.lcd_enable = 1'b1;
    tick(1);
    bus.lcd_enable = 1'b0;
    tick(1);
    rst = 1'b0;

    tick(32 + BUSY_CYCLES - 1);
    chk("init busy last cycle", 32'(busy), 32'd1);
    tick(1);
    chk("init busy released", 32'(busy), 32'd0);
    chk("init cursor", 32'(cursor), 32'd0);
    chk("init overrun", 32'(overrun), 32'd0);
    for (int a = 0; a < 32; a++) rd_chk(5'(a), 8'h20);

    // Set address 0x85, then two characters.
    send(1'b0, 1'b0, 8'h85);
    chk("setaddr busy", 32'(busy), 32'd1);
    chk("setaddr cursor", 32'(cursor), 32'd5);
    wait_idle("idle after 0x85");
    send(1'b1, 1'b0, 8'h41);
    wait_idle("idle after 0x41");
    send(1'b1, 1'b0, 8'h42);
    wait_idle("idle after 0x42");
    chk("cursor after text", 32'(cursor), 32'd7);
    rd_chk(5'd5, 8'h41);
    rd_chk(5'd6, 8'h42);
    rd_chk(5'd7, 8'h20);

    send(1'b0, 1'b0, 8'hCF);
    chk("setaddr 0xCF", 32'(cursor), 32'd31);
    wait_idle("idle after 0xCF");
    send(1'b0, 1'b0, 8'hC0);
    chk("setaddr 0xC0", 32'(cursor), 32'd16);
    wait_idle("idle after 0xC0");
    send(1'b0, 1'b0, 8'h02);
    chk("home cursor", 32'(cursor), 32'd0);
    wait_idle("idle after home");

    // Decrement mode and wrap below zero.
    send(1'b0, 1'b0, 8'h04);
    chk("entry decrement", 32'(increment), 32'd0);
    wait_idle("idle after 0x04");
    send(1'b0, 1'b0, 8'h80);
    wait_idle("idle after 0x80");
    send(1'b1, 1'b0, 8'h5A);
    chk("wrap cursor", 32'(cursor), 32'd31);
    wait_idle("idle after 0x5A");
    rd_chk(5'd0, 8'h5A);
    rd_chk(5'd31, 8'h20);

    // Reads on the bus are ignored altogether.
    send(1'b1, 1'b1, 8'h77);
    chk("rw busy", 32'(busy), 32'd0);
    chk("rw overrun", 32'(overrun), 32'd0);
    chk("rw cursor", 32'(cursor), 32'd31);

    // Second fall three cycles after the first lands while busy.
    send(1'b0, 1'b0, 8'h0C);
    tick(1);
    send(1'b0, 1'b0, 8'h08);
    chk("overrun set", 32'(overrun), 32'd1);
    wait_idle("idle after overrun");
    chk("display_on kept", 32'(display_on), 32'd1);
    chk("overrun sticky", 32'(overrun), 32'd1);

    // Clear in the middle of text.
    send(1'b0, 1'b0, 8'h85);
    wait_idle("idle before clear");
    send(1'b0, 1'b0, 8'h01);
    chk("clear cursor", 32'(cursor), 32'd0);
    chk("clear increment", 32'(increment), 32'd1);
    busy_len(n);
    chk("clear busy length", 32'(n), 32'(32 + BUSY_CYCLES));
    for (int a = 0; a < 32; a++) rd_chk(5'(a), 8'h20);

    // Reset while the clear sweep is at index 10.
    send(1'b0, 1'b0, 8'h8A);
    wait_idle("idle before mid-clear reset");
    send(1'b1, 1'b0, 8'h61);
    wait_idle("idle after 0x61");
    send(1'b0, 1'b0, 8'h01);
    tick(10);
    rst = 1'b1;
    #1;
    chk("midrst rd_data", 32'(rd_data), 32'h00);
    chk("midrst cursor", 32'(cursor), 32'd0);
    chk("midrst display_on", 32'(display_on), 32'd0);
    chk("midrst increment", 32'(increment), 32'd1);
    chk("midrst busy", 32'(busy), 32'd1);
    chk("midrst overrun", 32'(overrun), 32'd0);
    tick(2);
    rst = 1'b0;
    busy_len(n);
    chk("restart busy length", 32'(n), 32'(32 + BUSY_CYCLES));
    chk("restart overrun", 32'(overrun), 32'd0);
    rd_chk(5'd10, 8'h20);
    rd_chk(5'd0, 8'h20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
